// File: rtl/fifo_pkg.sv
// Shared widths and helpers for the FIFO read-side word unpacker.
package fifo_pkg;

   localparam int FIFO_DATA_W = 32;
   localparam int DEF_OUT_W   = 8;
   localparam int RATIO       = FIFO_DATA_W / DEF_OUT_W;
   localparam int IDX_W       = $clog2(RATIO);

   typedef enum logic {
      IDLE  = 1'b0,
      DRAIN = 1'b1
   } unpk_state_e;

   // A single-word frame still needs one counter bit.
   function automatic int fcnt_w(input int frames);
      return (frames > 1) ? $clog2(frames) : 1;
   endfunction

endpackage

// File: rtl/fifo_word_unpacker.sv
// Pops FWFT FIFO words and streams them out as narrow beats,
// flagging the final beat of every frame.
module fifo_word_unpacker
   import fifo_pkg::*;
#(
   parameter int DATA_W      = FIFO_DATA_W,
   parameter int OUT_W       = DEF_OUT_W,
   parameter int FRAME_WORDS = 4,
   parameter int LSB_FIRST   = 1
) (
   input  logic              read_clk,
   input  logic              read_rst_n,
   input  logic              enable,
   input  logic              fifo_readable,
   input  logic [DATA_W-1:0] fifo_dout,
   output logic              fifo_re,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [OUT_W-1:0]  out_data,
   output logic              out_last,
   output logic              busy
);

   localparam int BEATS = DATA_W / OUT_W;
   localparam int IW    = $clog2(BEATS);
   localparam int FW    = fcnt_w(FRAME_WORDS);
   localparam logic [IW-1:0] IDX_LAST  = IW'(BEATS - 1);
   localparam logic [FW-1:0] FCNT_LAST = FW'(FRAME_WORDS - 1);

   if (DATA_W % OUT_W != 0 || BEATS < 2 || FRAME_WORDS < 1) begin : g_bad
      $error("fifo_word_unpacker: illegal parameters");
   end

   unpk_state_e       state_q, state_d;
   logic [DATA_W-1:0] word_q, word_d;
   logic [IW-1:0]     idx_q, idx_d;
   logic [FW-1:0]     fcnt_q, fcnt_d;

   logic          accept;
   logic          last_beat;
   logic          pop;
   logic [IW-1:0] sel;

   assign busy      = (state_q == DRAIN);
   assign out_valid = busy;
   assign accept    = out_valid & out_ready;
   assign last_beat = (idx_q == IDX_LAST);
   assign pop       = enable & fifo_readable
                    & (~busy | (accept & last_beat));
   assign fifo_re   = read_rst_n & pop;
   assign out_last  = busy & last_beat & (fcnt_q == FCNT_LAST);
   assign sel       = (LSB_FIRST != 0) ? idx_q : IDX_LAST - idx_q;

   always_comb begin
      out_data = '0;
      for (int i = 0; i < BEATS; i++) begin
         if (sel == IW'(i)) out_data = word_q[i*OUT_W +: OUT_W];
      end
   end

   always_comb begin
      state_d = state_q;
      word_d  = word_q;
      idx_d   = idx_q;
      fcnt_d  = fcnt_q;
      if (accept) begin
         if (last_beat) begin
            state_d = IDLE;
            fcnt_d  = (fcnt_q == FCNT_LAST) ? '0 : fcnt_q + 1'b1;
         end else begin
            idx_d = idx_q + 1'b1;
         end
      end
      // A pop on the final beat overrides the return to IDLE.
      if (pop) begin
         state_d = DRAIN;
         word_d  = fifo_dout;
         idx_d   = '0;
      end
   end

   always_ff @(posedge read_clk or negedge read_rst_n) begin
      if (!read_rst_n) begin
         state_q <= IDLE;
         word_q  <= '0;
         idx_q   <= '0;
         fcnt_q  <= '0;
      end else begin
         state_q <= state_d;
         word_q  <= word_d;
         idx_q   <= idx_d;
         fcnt_q  <= fcnt_d;
      end
   end

endmodule

// File: doc/fifo_word_unpacker.md
Name: fifo_word_unpacker

Overview:
- Read-domain consumer placed directly downstream of the 32-bit asynchronous FIFO.
- Pops words through the FIFO's readable/re/dout port. The FIFO is first-word-fall-through: dout is valid whenever readable is high, and re advances the read pointer.
- Emits each word as OUT_W-bit beats on a valid/ready stream.
- Asserts out_last on the final beat of every FRAME_WORDS-word frame.

Parameters:
- DATA_W, 32, FIFO word width. Must be an integer multiple of OUT_W.
- OUT_W, 8, output beat width. RATIO = DATA_W/OUT_W, and RATIO must be at least 2.
- FRAME_WORDS, 4, words per frame. Must be at least 1.
- LSB_FIRST, 1, beat order. 1 sends word[OUT_W-1:0] first; 0 sends the most significant slice first.

Ports:
- read_clk  in  1  FIFO read-side clock; the only clock of this block.
- read_rst_n  in  1  asynchronous, active-low reset.
- enable  in  1  permits popping new words; a word already held still drains.
- fifo_readable  in  1  FIFO readable flag.
- fifo_dout  in  DATA_W  FIFO head word, valid while fifo_readable is high.
- fifo_re  out  1  FIFO pop strobe.
- out_valid  out  1  beat valid.
- out_ready  in  1  downstream accept.
- out_data  out  OUT_W  beat payload.
- out_last  out  1  final beat of a frame.
- busy  out  1  a word is held or being drained.

Behaviour:
- Clocking and reset:
  - One clock, read_clk. Reset read_rst_n is asynchronous and active-low.
  - While read_rst_n is low: out_valid=0, out_data=0, out_last=0, busy=0, beat index=0, frame counter=0, holding register=0.
  - fifo_re is forced to 0 while read_rst_n is low.
- State:
  - Holding register word_q (DATA_W bits).
  - Beat index idx, 0..RATIO-1, width clog2(RATIO).
  - Frame word counter fcnt, 0..FRAME_WORDS-1.
  - Two states, IDLE (busy=0) and DRAIN (busy=1). out_valid equals busy.
- Beat acceptance: accept = out_valid & out_ready.
- End of word: last_beat = (idx == RATIO-1).
- Pop condition: fifo_re = enable & fifo_readable & (~busy | (accept & last_beat)). fifo_re is combinational from inputs and state and is never asserted when fifo_readable is 0.
- On a pop: word_q <= fifo_dout, idx <= 0, next state is DRAIN.
- Transitions:
  - IDLE to DRAIN on a pop.
  - DRAIN, on accept with idx < RATIO-1: idx increments.
  - DRAIN, on accept with last_beat and a pop in the same cycle: stays in DRAIN with the new word. fcnt advances (wraps to 0 after FRAME_WORDS-1).
  - DRAIN, on accept with last_beat and no pop: goes to IDLE. fcnt advances.
- Output data:
  - LSB_FIRST=1: out_data = word_q[idx*OUT_W +: OUT_W].
  - LSB_FIRST=0: out_data = word_q[(RATIO-1-idx)*OUT_W +: OUT_W].
  - out_data is held stable while out_valid & ~out_ready (standard valid/ready rule).
- Frame marker: out_last = busy & last_beat & (fcnt == FRAME_WORDS-1). With FRAME_WORDS=1, every word's final beat is last.
- Latency and throughput:
  - fifo_readable rising in IDLE with enable=1 gives a pop that cycle and out_valid=1 on the next edge.
  - With out_ready held high and the FIFO non-empty: one beat per cycle, no bubble between words. Sustained rate is RATIO beats per word.
- Backpressure: with out_ready low, no further pop occurs; the FIFO fills and its writer sees writable fall.
- Enable: deasserting enable mid-word finishes the current word and then returns to IDLE. fcnt is retained, so frame alignment survives pauses.
- Empty FIFO: fifo_readable low on last_beat accept gives IDLE, out_valid=0 next cycle, no spurious pop.
- Reset mid-word: the held word and any partial frame are discarded; unpopped FIFO words are untouched. After reset the next frame starts at fcnt=0.

Decomposition:
- Shared package fifo_pkg:
  - FIFO_DATA_W=32.
  - Default OUT_W=8.
  - Localparam formulas for RATIO and IDX_W=clog2(RATIO).
  - Function for FCNT_W.
- No sub-module: the FSM, the two counters and the slice mux stay inline. The block is about 150 lines.

Test Plan:
- Reset with fifo_readable=1 and read_rst_n=0 -> fifo_re=0 and all outputs 0. Release reset with enable=1 and dout=0x44332211 -> one pop, then out_data 0x11,0x22,0x33,0x44 on 4 consecutive cycles with out_ready=1.
- Stream 8 words, FRAME_WORDS=4, out_ready=1 -> 32 consecutive beats, out_last only on beats 16 and 32, fifo_re pulses exactly on the cycles of beats 4, 8, ... and not after word 8.
- Backpressure: toggle out_ready 1,0,0,1 during word 0xDEADBEEF -> bytes EF,BE,AD,DE emitted in order, out_data held during stall cycles, no pop before DE is accepted.
- Drop enable after the pop of word 2 of 4 -> word 2 fully drained then IDLE. Re-enable -> word 3 final beat carries out_last (fcnt=3 preserved).
- Assert read_rst_n=0 at beat idx=2 of a word -> outputs 0 asynchronously. After release, the next FIFO word starts at idx=0, and out_last is at its frame position counted from 0.
- LSB_FIRST=0, dout=0xA1B2C3D4 -> beats A1,B2,C3,D4.
